// File: rtl/gate_trainer_sequencer_pkg.sv
// Shared definitions for the gate trainer sequencer: gate indices, FSM states
// and the reference truth table for each gate.
package trainer_pkg;

    localparam logic [2:0] GATE_AND     = 3'd0;
    localparam logic [2:0] GATE_OR      = 3'd1;
    localparam logic [2:0] GATE_NOT_A   = 3'd2;
    localparam logic [2:0] GATE_NAND    = 3'd3;
    localparam logic [2:0] GATE_NOR     = 3'd4;
    localparam logic [2:0] GATE_XOR     = 3'd5;
    localparam logic [2:0] GATE_XNOR    = 3'd6;
    localparam logic [2:0] GATE_INVALID = 3'd7;

    localparam int NUM_VECTORS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Bit i of the table is the gate output for {a,b} = i.
    function automatic logic [3:0] expected_tt(input logic [2:0] sel);
        case (sel)
            GATE_AND:   return 4'b1000;
            GATE_OR:    return 4'b1110;
            GATE_NOT_A: return 4'b0011;
            GATE_NAND:  return 4'b0111;
            GATE_NOR:   return 4'b0001;
            GATE_XOR:   return 4'b0110;
            GATE_XNOR:  return 4'b1001;
            default:    return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/gate_trainer_sequencer_if.sv
// Board-side signal bundle of the gate trainer sequencer.
// Optional mismatch output present when TRAINER_MISMATCH_EN is defined.
interface gate_trainer_sequencer_if;

    logic       start;
    logic [2:0] gate_sel;
    logic       step_mode;
    logic       step_btn;
    logic [6:0] gate_res;
    logic       a_drv;
    logic       b_drv;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic       pass;
    logic       sel_err;
`ifdef TRAINER_MISMATCH_EN
    logic [3:0] mismatch;
`endif

    modport master (
        output start, gate_sel, step_mode, step_btn, gate_res,
        input  a_drv, b_drv, busy, done, truth_table, pass, sel_err
`ifdef TRAINER_MISMATCH_EN
        , input mismatch
`endif
    );

    modport slave (
        input  start, gate_sel, step_mode, step_btn, gate_res,
        output a_drv, b_drv, busy, done, truth_table, pass, sel_err
`ifdef TRAINER_MISMATCH_EN
        , output mismatch
`endif
    );

endinterface

// File: rtl/gate_trainer_sequencer_dwell_timer.sv
// Dwell counter for auto mode: counts enabled cycles and flags the last one.
module dwell_timer #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == CW'(HOLD - 1));

endmodule

// File: rtl/gate_trainer_sequencer.sv
// Truth-table exerciser for the two-input trainer gate bank.
// Define TRAINER_MISMATCH_EN to add the per-vector mismatch output.
module gate_trainer_sequencer
    import trainer_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    gate_trainer_sequencer_if.slave bus
);

    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] vec;
    logic [2:0] sel_q;
    logic       step_q;
    logic [1:0] ab_q;
    logic [3:0] tt_q;
    logic       pass_q;
    logic       sel_err_q;
    logic       busy_c;
    logic       done_c;
    logic       timer_en;
    logic       timer_clr;
    logic       expire;
    logic       advance;
    logic [7:0] res_ext;
`ifdef TRAINER_MISMATCH_EN
    logic [3:0] mismatch_q;
`endif

    // The timer only runs in auto mode; it restarts from zero on every APPLY entry.
    assign timer_en  = (state == ST_APPLY) && !step_q;
    assign timer_clr = (state != ST_APPLY);
    assign advance   = step_q ? bus.step_btn : expire;
    assign res_ext   = {1'b0, bus.gate_res};

    dwell_timer #(
        .HOLD(HOLD_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clr),
        .enable (timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.gate_sel == GATE_INVALID) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY: begin
                busy_c = 1'b1;
                if (advance) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy_c    = 1'b1;
                state_nxt = (vec == LAST_VEC) ? ST_CHECK : ST_APPLY;
            end
            ST_CHECK: begin
                busy_c    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The drive register follows vec, so a/b stay valid through APPLY and SAMPLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec       <= '0;
            sel_q     <= '0;
            step_q    <= 1'b0;
            ab_q      <= '0;
            tt_q      <= '0;
            pass_q    <= 1'b0;
            sel_err_q <= 1'b0;
`ifdef TRAINER_MISMATCH_EN
            mismatch_q <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        pass_q <= 1'b0;
`ifdef TRAINER_MISMATCH_EN
                        mismatch_q <= '0;
`endif
                        if (bus.gate_sel == GATE_INVALID) begin
                            sel_err_q <= 1'b1;
                        end else begin
                            sel_err_q <= 1'b0;
                            sel_q     <= bus.gate_sel;
                            step_q    <= bus.step_mode;
                            tt_q      <= '0;
                            vec       <= '0;
                            ab_q      <= '0;
                        end
                    end
                end
                ST_SAMPLE: begin
                    tt_q[vec] <= res_ext[sel_q];
                    if (vec != LAST_VEC) begin
                        vec  <= vec + 2'd1;
                        ab_q <= vec + 2'd1;
                    end
                end
                ST_CHECK: begin
                    pass_q <= (tt_q == expected_tt(sel_q));
`ifdef TRAINER_MISMATCH_EN
                    mismatch_q <= tt_q ^ expected_tt(sel_q);
`endif
                    ab_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.a_drv       = ab_q[1];
    assign bus.b_drv       = ab_q[0];
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.truth_table = tt_q;
    assign bus.pass        = pass_q;
    assign bus.sel_err     = sel_err_q;
`ifdef TRAINER_MISMATCH_EN
    assign bus.mismatch    = mismatch_q;
`endif

endmodule

// File: tb/tb_gate_trainer_sequencer.sv
// Self-checking bench for gate_trainer_sequencer with a behavioural gate bank
// and truth-table reference; mismatch checks are active under TRAINER_MISMATCH_EN.
module tb_gate_trainer_sequencer;

    localparam int H = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [2:0] fault_gate;
    logic [3:0] fault_mask;
    int         step_gaps[4];

    gate_trainer_sequencer_if bus ();
    gate_trainer_sequencer_if bus1 ();

    gate_trainer_sequencer #(.HOLD_CYCLES(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    gate_trainer_sequencer #(.HOLD_CYCLES(1)) dut_h1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate bank output vector {xnor,xor,nor,nand,not_a,or,and} for given inputs.
    function automatic logic [6:0] ideal_bank(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    function automatic logic [3:0] ref_table(input logic [2:0] sel);
        logic [3:0] t;
        logic [6:0] r;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            r    = ideal_bank(i >= 2, (i % 2) == 1);
            t[i] = r[sel];
        end
        return t;
    endfunction

    assign bus.gate_res  = ideal_bank(bus.a_drv, bus.b_drv)
                         & ~(fault_mask[{bus.a_drv, bus.b_drv}] ? (7'b1 << fault_gate) : 7'b0);
    assign bus1.gate_res = ideal_bank(bus1.a_drv, bus1.b_drv);

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.a_drv, bus.b_drv, bus.busy, bus.done, bus.truth_table, bus.pass, bus.sel_err} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b want=0",
                     {bus.a_drv, bus.b_drv, bus.busy, bus.done, bus.truth_table, bus.pass, bus.sel_err});
        end
`ifdef TRAINER_MISMATCH_EN
        checks++;
        if (bus.mismatch !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_mismatch got=%b want=0000", bus.mismatch);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_auto_run(input logic [2:0] sel, input logic [3:0] fmask, input logic scramble);
        logic [3:0] ideal;
        logic [3:0] exp_tt;
        logic [1:0] exp_ab;
        ideal  = ref_table(sel);
        exp_tt = ideal & ~fmask;
        @(negedge clk);
        fault_gate    = sel;
        fault_mask    = fmask;
        bus.gate_sel  = sel;
        bus.step_mode = 1'b0;
        bus.start     = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
            checks++;
            if ({bus.busy, bus.done} !== {(k <= 20), (k == 21)}) begin
                errors++;
                $display("[TB] FAIL auto_busy_done sel=%0d k=%0d got=%b want=%b",
                         sel, k, {bus.busy, bus.done}, {(k <= 20), (k == 21)});
            end
            if (k != 20) begin
                exp_ab = (k <= 19) ? 2'(k / (H + 1)) : 2'b00;
                checks++;
                if ({bus.a_drv, bus.b_drv} !== exp_ab) begin
                    errors++;
                    $display("[TB] FAIL auto_ab sel=%0d k=%0d got=%b want=%b",
                             sel, k, {bus.a_drv, bus.b_drv}, exp_ab);
                end
            end
            if (k == 21) begin
                checks++;
                if ({bus.truth_table, bus.pass, bus.sel_err} !== {exp_tt, exp_tt == ideal, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL auto_result sel=%0d got tt=%b pass=%b sel_err=%b want tt=%b pass=%b sel_err=0",
                             sel, bus.truth_table, bus.pass, bus.sel_err, exp_tt, exp_tt == ideal);
                end
`ifdef TRAINER_MISMATCH_EN
                checks++;
                if (bus.mismatch !== (exp_tt ^ ideal)) begin
                    errors++;
                    $display("[TB] FAIL auto_mismatch sel=%0d got=%b want=%b", sel, bus.mismatch, exp_tt ^ ideal);
                end
`endif
            end
            if (scramble && k < 20) begin
                bus.gate_sel  = 3'($urandom_range(0, 7));
                bus.step_mode = 1'($urandom);
            end
        end
        bus.step_mode = 1'b0;
        fault_mask    = '0;
    endtask

    task automatic test_xor_fault();
        test_auto_run(3'd5, 4'b1000, 1'b0);
        test_auto_run(3'd5, 4'b0010, 1'b0);
    endtask

    task automatic test_sel_err();
        @(negedge clk);
        bus.gate_sel = 3'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.done, bus.busy, bus.sel_err, bus.pass, bus.a_drv, bus.b_drv} !== 6'b101000) begin
            errors++;
            $display("[TB] FAIL sel_err_run got=%b want=101000",
                     {bus.done, bus.busy, bus.sel_err, bus.pass, bus.a_drv, bus.b_drv});
        end
`ifdef TRAINER_MISMATCH_EN
        checks++;
        if (bus.mismatch !== 4'b0) begin
            errors++;
            $display("[TB] FAIL sel_err_mismatch got=%b want=0000", bus.mismatch);
        end
`endif
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.done, bus.busy, bus.sel_err, bus.a_drv, bus.b_drv} !== 5'b00100) begin
                errors++;
                $display("[TB] FAIL sel_err_after k=%0d got=%b want=00100",
                         k, {bus.done, bus.busy, bus.sel_err, bus.a_drv, bus.b_drv});
            end
        end
    endtask

    task automatic test_step_mode(input logic [2:0] sel);
        logic [3:0] ideal;
        ideal = ref_table(sel);
        @(negedge clk);
        bus.step_btn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.step_btn = 1'b0;
        checks++;
        if ({bus.busy, bus.a_drv, bus.b_drv} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL step_idle_ignored got=%b want=000", {bus.busy, bus.a_drv, bus.b_drv});
        end
        bus.gate_sel  = sel;
        bus.step_mode = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.step_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (step_gaps[i]) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if ({bus.busy, bus.a_drv, bus.b_drv} !== {1'b1, 2'(i)}) begin
                    errors++;
                    $display("[TB] FAIL step_hold vec=%0d got=%b want=%b",
                             i, {bus.busy, bus.a_drv, bus.b_drv}, {1'b1, 2'(i)});
                end
            end
            bus.step_btn = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.step_btn = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if ({bus.a_drv, bus.b_drv} !== 2'(i + 1)) begin
                    errors++;
                    $display("[TB] FAIL step_advance vec=%0d got=%b want=%b",
                             i, {bus.a_drv, bus.b_drv}, 2'(i + 1));
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.done, bus.truth_table, bus.pass} !== {1'b1, ideal, 1'b1}) begin
            errors++;
            $display("[TB] FAIL step_result sel=%0d got done=%b tt=%b pass=%b want done=1 tt=%b pass=1",
                     sel, bus.done, bus.truth_table, bus.pass, ideal);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus.gate_sel = 3'd1;
        bus.start    = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if ({bus.a_drv, bus.b_drv, bus.truth_table} !== 6'b10_0010) begin
            errors++;
            $display("[TB] FAIL reset_mid_pre got=%b want=100010", {bus.a_drv, bus.b_drv, bus.truth_table});
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.a_drv, bus.b_drv, bus.busy, bus.done, bus.truth_table, bus.pass, bus.sel_err} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs got=%b want=0",
                     {bus.a_drv, bus.b_drv, bus.busy, bus.done, bus.truth_table, bus.pass, bus.sel_err});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_idle got busy=%b want 0", bus.busy);
        end
        test_auto_run(3'd1, 4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        fault_mask    = '0;
        bus.gate_sel  = 3'd0;
        bus.step_mode = 1'b0;
        bus.start     = 1'b1;
        for (int k = 0; k <= 44; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 2) bus.gate_sel = 3'd3;
            if (k == 21 || k == 44) begin
                checks++;
                if ({bus.done, bus.truth_table, bus.pass} !== {1'b1, ref_table((k == 21) ? 3'd0 : 3'd3), 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL b2b_result k=%0d got done=%b tt=%b pass=%b want tt=%b",
                             k, bus.done, bus.truth_table, bus.pass, ref_table((k == 21) ? 3'd0 : 3'd3));
                end
            end
            if (k == 22 || k == 23) begin
                checks++;
                if ({bus.busy, bus.done} !== {(k == 23), 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL b2b_restart k=%0d got=%b want=%b", k, {bus.busy, bus.done}, {(k == 23), 1'b0});
                end
                if (k == 23) bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_hold_one();
        logic [2:0] sel;
        sel = 3'($urandom_range(0, 6));
        @(negedge clk);
        bus1.gate_sel = sel;
        bus1.start    = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            checks++;
            if ({bus1.busy, bus1.done} !== {(k <= 8), (k == 9)}) begin
                errors++;
                $display("[TB] FAIL hold1_busy_done k=%0d got=%b want=%b", k, {bus1.busy, bus1.done}, {(k <= 8), (k == 9)});
            end
            if (k <= 7) begin
                checks++;
                if ({bus1.a_drv, bus1.b_drv} !== 2'(k / 2)) begin
                    errors++;
                    $display("[TB] FAIL hold1_ab k=%0d got=%b want=%b", k, {bus1.a_drv, bus1.b_drv}, 2'(k / 2));
                end
            end
            if (k == 9) begin
                checks++;
                if ({bus1.truth_table, bus1.pass} !== {ref_table(sel), 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL hold1_result sel=%0d got tt=%b pass=%b want tt=%b pass=1",
                             sel, bus1.truth_table, bus1.pass, ref_table(sel));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            test_auto_run(3'($urandom_range(0, 6)), 4'($urandom), 1'b1);
        end
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 4; i++) step_gaps[i] = $urandom_range(1, 12);
            test_step_mode(3'($urandom_range(0, 6)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        fault_gate    = '0;
        fault_mask    = '0;
        bus.start     = 1'b0;
        bus.gate_sel  = '0;
        bus.step_mode = 1'b0;
        bus.step_btn  = 1'b0;
        bus1.start    = 1'b0;
        bus1.gate_sel = '0;
        bus1.step_mode = 1'b0;
        bus1.step_btn = 1'b0;

        test_reset();
        test_auto_run(3'd0, 4'b0000, 1'b0);
        test_xor_fault();
        test_auto_run(3'd6, 4'b0000, 1'b0);
        test_sel_err();
        test_auto_run(3'd2, 4'b0000, 1'b0);
        step_gaps = '{3, 10, 1, 7};
        test_step_mode(3'd2);
        test_reset_mid_run();
        test_back_to_back();
        test_hold_one();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_trainer_sequencer.md
Name: gate_trainer_sequencer

Overview:
- Automatic truth-table exerciser for the two-input digital trainer gate bank.
- On start it drives the gate inputs a,b through 00, 01, 10, 11 and holds each vector for a dwell time.
- It samples the selected gate output for each vector, builds a 4-bit truth table and compares it with the expected table for that gate.
- Sits between the board buttons/switches and the gate bank. The top level wires a_drv/b_drv to the gate inputs and the seven gate outputs back into gate_res.

Parameters:
- HOLD_CYCLES, 4: dwell cycles per vector in auto mode; legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  level; sampled only in IDLE
- gate_sel  input  3  0=AND 1=OR 2=NOT_A 3=NAND 4=NOR 5=XOR 6=XNOR, 7=invalid
- step_mode  input  1  1 = advance on step_btn instead of dwell timer
- step_btn  input  1  single-cycle pulse, already debounced upstream
- gate_res  input  7  {xnor,xor,nor,nand,not_a,or,and} from gate bank, bit index = gate_sel
- a_drv  output  1  gate input a
- b_drv  output  1  gate input b
- busy  output  1  high from the first APPLY through CHECK
- done  output  1  one-cycle pulse at end of run
- truth_table  output  4  bit i = sampled result for {a,b}=i; held until next run
- pass  output  1  truth_table matches expected; valid from done, held
- sel_err  output  1  last start had gate_sel=7; held

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; all outputs 0; vector index and dwell counter 0.
  - Applies mid-run too: a_drv/b_drv return to 0, partial table discarded.
- States: IDLE, APPLY, SAMPLE, CHECK, DONE.
- IDLE:
  - start=1 with gate_sel≤6: latch gate_sel, clear truth_table/pass/sel_err, vec=0, cnt=0, go to APPLY.
  - start=1 with gate_sel=7: set sel_err=1, pass=0, go to DONE; no vectors driven.
- APPLY:
  - {a_drv,b_drv}=vec, registered.
  - Auto mode: cnt increments each cycle; when cnt==HOLD_CYCLES-1, go to SAMPLE.
  - Step mode: stay until step_btn=1, then go to SAMPLE; cnt unused.
- SAMPLE:
  - truth_table[vec] <= gate_res[sel_latched]; a/b are still driven.
  - If vec==3, go to CHECK; else vec++, cnt=0, go to APPLY.
- CHECK: pass <= (truth_table == EXPECTED[sel_latched]); go to DONE.
- DONE: done=1 for exactly one cycle; a_drv=b_drv=0; go to IDLE.
- Expected tables (bit3..bit0): AND 1000, OR 1110, NOT_A 0011, NAND 0111, NOR 0001, XOR 0110, XNOR 1001.
- Latency (auto mode): done is high in the cycle after clock edge 4*(HOLD_CYCLES+1)+1, counting the edge that sampled start as edge 0. HOLD_CYCLES=4 gives edge 21.
- Boundary cases:
  - start, gate_sel, step_mode changes while busy: ignored; gate_sel and step_mode are latched at start.
  - step_btn outside APPLY: ignored.
  - start held high continuously: a new run begins on the cycle after DONE, because IDLE is re-entered and samples start.
  - HOLD_CYCLES=1: each vector takes APPLY 1 cycle + SAMPLE 1 cycle.
- Counter width: $clog2(HOLD_CYCLES+1); no wrap is possible within a run.

Optional Feature:
- Macro: TRAINER_MISMATCH_EN.
- Defined:
  - Adds output mismatch[3:0] = truth_table ^ expected, registered in CHECK, held with pass.
  - Cleared at start and at reset.
  - Cleared to 0 on a sel_err run.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- trainer_pkg:
  - gate index localparams (GATE_AND..GATE_XNOR, GATE_INVALID=7);
  - state enum;
  - function expected_tt(sel) returning the 4-bit table;
  - NUM_VECTORS=4.
- Sub-module dwell_timer: holds the counter. Interface: clear, enable, HOLD parameter, expire output. The FSM stays in gate_trainer_sequencer.

Test Plan:
- Auto run, gate_sel=0, HOLD_CYCLES=4, real gate bank in loop → a/b sequence 00,01,10,11 with 4 cycles each; truth_table=1000; pass=1; done pulse after edge 21.
- gate_sel=5, gate_res[5] forced to 0 for vector 11 → truth_table=0110, pass=1. Then force vector 01 to 0 → truth_table=0100, pass=0, mismatch=0010 (with TRAINER_MISMATCH_EN).
- step_mode=1, gate_sel=2, step_btn pulsed at irregular gaps (3, 10, 1, 7 cycles) → a/b advance only on pulses; truth_table=0011; pass=1.
- gate_sel=7 with start → sel_err=1, pass=0; done one cycle after start edge; a_drv/b_drv stay 0.
- rst_n=0 for one edge during vector 10 → all outputs 0 next cycle, state IDLE. A new start gives a clean full run.
- start held high and gate_sel changed mid-run → first run uses the latched sel. Second run starts right after done and uses the new sel.
